// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage lane-parallel ALU with valid/ready handshake and flush.
// Define SIMD_SATURATE_EN to build signed saturating add/sub for opcodes 12/13.
module simd_alu_pipe #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int TAG_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [LANES*LANE_W-1:0] in_s1,
  input  logic [LANES*LANE_W-1:0] in_s2,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [LANES-1:0]        out_flags,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int DW   = LANES * LANE_W;
  localparam int SH_W = $clog2(LANE_W);

  logic            s1_valid_q, s1_valid_d;
  logic [3:0]      s1_op_q, s1_op_d;
  logic [DW-1:0]   s1_a_q, s1_a_d;
  logic [DW-1:0]   s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic            s2_valid_q, s2_valid_d;
  logic [DW-1:0]   s2_data_q, s2_data_d;
  logic [LANES-1:0] s2_flags_q, s2_flags_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic            s2_load;
  logic [DW-1:0]   alu_data;
  logic [LANES-1:0] alu_flags;
  logic [LANE_W:0] lane_res;

  // Returns {flag, result} for one lane; reserved opcodes give result 0, flag 1.
  function automatic logic [LANE_W:0] lane_op(input logic [3:0] op,
                                              input logic [LANE_W-1:0] a,
                                              input logic [LANE_W-1:0] b);
    logic [SH_W-1:0]   sh;
    logic              sel;
    logic [LANE_W:0]   res;
`ifdef SIMD_SATURATE_EN
    logic [LANE_W-1:0] sum;
    logic              b_eff_sign;
    logic              ovf;
`endif
    sh  = b[SH_W-1:0];
    sel = 1'b0;
    res = {1'b1, {LANE_W{1'b0}}};
    case (op)
      4'd0:  res = {1'b0, a} + {1'b0, b};
      4'd1:  res = {1'b0, a} - {1'b0, b};
      4'd2:  res = {1'b0, a & b};
      4'd3:  res = {1'b0, a | b};
      4'd4:  res = {1'b0, a ^ b};
      4'd5:  res = {1'b0, a << sh};
      4'd6:  res = {1'b0, a >> sh};
      4'd7:  res = {1'b0, $unsigned($signed(a) >>> sh)};
      4'd8:  begin sel = ($signed(a) <= $signed(b)); res = {sel, sel ? a : b}; end
      4'd9:  begin sel = ($signed(a) >= $signed(b)); res = {sel, sel ? a : b}; end
      4'd10: begin sel = (a <= b); res = {sel, sel ? a : b}; end
      4'd11: begin sel = (a >= b); res = {sel, sel ? a : b}; end
`ifdef SIMD_SATURATE_EN
      // Overflow only when effective operand signs agree and the result sign flips.
      4'd12, 4'd13: begin
        sum        = (op == 4'd12) ? a + b : a - b;
        b_eff_sign = (op == 4'd12) ? b[LANE_W-1] : ~b[LANE_W-1];
        ovf        = (a[LANE_W-1] == b_eff_sign) && (sum[LANE_W-1] != a[LANE_W-1]);
        if (ovf)
          res = a[LANE_W-1] ? {2'b11, {(LANE_W-1){1'b0}}} : {2'b10, {(LANE_W-1){1'b1}}};
        else
          res = {1'b0, sum};
      end
`endif
      default: res = {1'b1, {LANE_W{1'b0}}};
    endcase
    return res;
  endfunction

  always_comb begin
    lane_res  = '0;
    alu_data  = '0;
    alu_flags = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_res = lane_op(s1_op_q, s1_a_q[i*LANE_W +: LANE_W], s1_b_q[i*LANE_W +: LANE_W]);
      alu_data[i*LANE_W +: LANE_W] = lane_res[LANE_W-1:0];
      alu_flags[i] = lane_res[LANE_W];
    end
  end

  // S1 may refill in the same cycle it hands off to S2, so there is no bubble.
  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_load;
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_flags_d = s2_flags_q;
    s2_tag_d   = s2_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_data_d  = alu_data;
          s2_flags_d = alu_flags;
          s2_tag_d   = s1_tag_q;
        end
      end
      if (in_ready) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_op_d  = in_op;
          s1_a_d   = in_s1;
          s1_b_d   = in_s2;
          s1_tag_d = in_tag;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_flags_q <= s2_flags_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_flags = s2_flags_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: directed vectors plus a per-cycle scoreboard for simd_alu_pipe.
// Honours SIMD_SATURATE_EN the same way as the design.
module tb_simd_alu_pipe;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int TAG_W  = 5;
  localparam int DW     = LANES * LANE_W;
  localparam longint FULL = 256;
  localparam longint HALF = 128;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [DW-1:0]    in_s1;
  logic [DW-1:0]    in_s2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [LANES-1:0] out_flags;
  logic [TAG_W-1:0] out_tag;

  logic ready_man;
  logic ready_rnd = 1'b1;
  logic rand_ready;

  int total = 0;
  int bad = 0;
  int delivered = 0;

  logic [TAG_W+LANES+DW-1:0] exp_q[$];
  logic [TAG_W+LANES+DW-1:0] got_w;
  logic [TAG_W+LANES+DW-1:0] discard;

  logic [DW-1:0] vec_a[6] = '{32'h01FF7F80, 32'h7F800AF6, 32'h80808080,
                              32'h12345678, 32'hFFFFFFFF, 32'h00050A01};
  logic [DW-1:0] vec_b[6] = '{32'h01010101, 32'h01FF05FB, 32'h01020307,
                              32'h9ABCDEF0, 32'hFFFFFFFF, 32'h0106FF01};

  simd_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_s1(in_s1), .in_s2(in_s2), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    ready_rnd = 1'($urandom_range(0, 1));
  end

  assign out_ready = rand_ready ? ready_rnd : ready_man;
  assign got_w = {out_tag, out_flags, out_data};

  // Reference behaviour from plain integer arithmetic; returns {flags, data}.
  function automatic logic [LANES+DW-1:0] model_op(input logic [3:0] op,
                                                   input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b);
    logic [DW-1:0]    d_all;
    logic [LANES-1:0] f_all;
    longint ua, ub, sa, sb, r, d;
    int sh;
    logic f;
    d_all = '0;
    f_all = '0;
    for (int i = 0; i < LANES; i++) begin
      ua = longint'(a[i*LANE_W +: LANE_W]);
      ub = longint'(b[i*LANE_W +: LANE_W]);
      sa = (ua >= HALF) ? ua - FULL : ua;
      sb = (ub >= HALF) ? ub - FULL : ub;
      sh = int'(ub % LANE_W);
      f = 1'b0;
      d = 0;
      r = 0;
      case (op)
        4'd0:  begin r = ua + ub; d = r % FULL; f = (r >= FULL); end
        4'd1:  begin d = (ua - ub + FULL) % FULL; f = (ua < ub); end
        4'd2:  d = ua & ub;
        4'd3:  d = ua | ub;
        4'd4:  d = ua ^ ub;
        4'd5:  d = (ua << sh) % FULL;
        4'd6:  d = ua >> sh;
        4'd7:  begin r = sa >>> sh; d = (r + FULL) % FULL; end
        4'd8:  begin f = (sa <= sb); d = f ? ua : ub; end
        4'd9:  begin f = (sa >= sb); d = f ? ua : ub; end
        4'd10: begin f = (ua <= ub); d = f ? ua : ub; end
        4'd11: begin f = (ua >= ub); d = f ? ua : ub; end
`ifdef SIMD_SATURATE_EN
        4'd12, 4'd13: begin
          r = (op == 4'd12) ? sa + sb : sa - sb;
          if (r > HALF - 1) begin r = HALF - 1; f = 1'b1; end
          else if (r < -HALF) begin r = -HALF; f = 1'b1; end
          d = (r + FULL) % FULL;
        end
`endif
        default: begin d = 0; f = 1'b1; end
      endcase
      d_all[i*LANE_W +: LANE_W] = d[LANE_W-1:0];
      f_all[i] = f;
    end
    return {f_all, d_all};
  endfunction

  // Scoreboard: every valid output cycle must match the oldest outstanding op.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("[TB] FAIL stream_unexpected got=%h want=none", got_w);
        end else if (got_w !== exp_q[0]) begin
          bad = bad + 1;
          $display("[TB] FAIL stream_result got=%h want=%h", got_w, exp_q[0]);
        end
        if (out_ready) begin
          delivered = delivered + 1;
          if (exp_q.size() > 0) discard = exp_q.pop_front();
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_tag, model_op(in_op, in_s1, in_s2)});
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Offers one op and holds it until accepted; returns at posedge+1 after acceptance.
  task automatic applyStimulus(input logic [3:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [TAG_W-1:0] tag);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_s1 = a;
    in_s2 = b;
    in_tag = tag;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total = total + 1;
      bad = bad + 1;
      $display("[TB] FAIL accept_timeout got=stalled want=accepted tag=%0d", tag);
    end
  endtask

  task automatic checkResult(input string name, input logic [DW-1:0] data,
                             input logic [LANES-1:0] flags, input logic [TAG_W-1:0] tag);
    checkOutput({name, "_early"}, 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    checkOutput({name, "_valid"}, 64'(out_valid), 64'(1));
    checkOutput({name, "_data"}, 64'(out_data), 64'(data));
    checkOutput({name, "_flags"}, 64'(out_flags), 64'(flags));
    checkOutput({name, "_tag"}, 64'(out_tag), 64'(tag));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running want=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_s1 = '0;
    in_s2 = '0;
    in_tag = '0;
    flush = 1'b0;
    ready_man = 1'b1;
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    checkOutput("rst_out_flags", 64'(out_flags), 64'(0));
    checkOutput("rst_out_tag", 64'(out_tag), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));

    checkOutput("model_add", 64'(model_op(4'd0, 32'h01FF7F80, 32'h01010101)), 64'({4'b0100, 32'h02008081}));
    checkOutput("model_sub", 64'(model_op(4'd1, 32'h00050A01, 32'h0106FF01)), 64'({4'b1110, 32'hFFFF0B00}));
    checkOutput("model_sra", 64'(model_op(4'd7, 32'h80808080, 32'h01020307)), 64'({4'b0000, 32'hC0E0F0FF}));

    applyStimulus(4'd0, 32'h01FF7F80, 32'h01010101, 5'd5);
    checkResult("add", 32'h02008081, 4'b0100, 5'd5);
    applyStimulus(4'd12, 32'h7F800AF6, 32'h01FF05FB, 5'd6);
`ifdef SIMD_SATURATE_EN
    checkResult("adds", 32'h7F800FF1, 4'b1100, 5'd6);
`else
    checkResult("adds", 32'h00000000, 4'b1111, 5'd6);
`endif
    applyStimulus(4'd7, 32'h80808080, 32'h01020307, 5'd7);
    checkResult("sra", 32'hC0E0F0FF, 4'b0000, 5'd7);

    rand_ready = 1'b1;
    for (int op = 0; op < 16; op++)
      for (int v = 0; v < 6; v++)
        applyStimulus(4'(op), vec_a[v], vec_b[v], 5'(op * 6 + v));
    rand_ready = 1'b0;
    ready_man = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("sweep_drain", 64'(exp_q.size()), 64'(0));

    // Backpressure: two ops fill the pipe, the third waits while the output stalls.
    ready_man = 1'b0;
    in_valid = 1'b1;
    in_op = 4'd0;
    in_s1 = 32'h01020304;
    in_s2 = 32'h10203040;
    in_tag = 5'd1;
    @(negedge clk);
    checkOutput("bp_ready_t1", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_tag = 5'd2;
    @(negedge clk);
    checkOutput("bp_ready_t2", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_tag = 5'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_stall_ready", 64'(in_ready), 64'(0));
      checkOutput("bp_stall_valid", 64'(out_valid), 64'(1));
      checkOutput("bp_stall_tag", 64'(out_tag), 64'(1));
      checkOutput("bp_stall_data", 64'(out_data), 64'(32'h11223344));
      @(posedge clk);
      #1;
    end
    ready_man = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready", 64'(in_ready), 64'(1));
    checkOutput("bp_deliver_t1", 64'(out_tag), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_valid_t2", 64'(out_valid), 64'(1));
    checkOutput("bp_deliver_t2", 64'(out_tag), 64'(2));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_valid_t3", 64'(out_valid), 64'(1));
    checkOutput("bp_deliver_t3", 64'(out_tag), 64'(3));
    @(posedge clk);
    #1;
    checkOutput("bp_empty", 64'(out_valid), 64'(0));

    // Flush with both stages full and a new op offered.
    ready_man = 1'b0;
    in_valid = 1'b1;
    in_tag = 5'd10;
    @(posedge clk);
    #1;
    in_tag = 5'd11;
    @(posedge clk);
    #1;
    in_tag = 5'd12;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_full_valid", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_out_valid", 64'(out_valid), 64'(0));
    ready_man = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("flush_quiet", 64'(out_valid), 64'(0));
    end

    // Flush beats acceptance even when the pipe could take the op.
    in_valid = 1'b1;
    in_tag = 5'd13;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_drop_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("flush_drop_quiet", 64'(out_valid), 64'(0));
    end

    // Reset in the middle of a stalled stream.
    ready_man = 1'b0;
    in_valid = 1'b1;
    in_tag = 5'd20;
    @(posedge clk);
    #1;
    in_tag = 5'd21;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_valid", 64'(out_valid), 64'(0));
    checkOutput("midrst_data", 64'(out_data), 64'(0));
    checkOutput("midrst_flags", 64'(out_flags), 64'(0));
    checkOutput("midrst_tag", 64'(out_tag), 64'(0));
    rst_n = 1'b1;
    ready_man = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("midrst_quiet", 64'(out_valid), 64'(0));
    end
    checkOutput("midrst_in_ready", 64'(in_ready), 64'(1));

    checkOutput("final_queue", 64'(exp_q.size()), 64'(0));
    checkOutput("delivered", 64'(delivered), 64'(102));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
